// File: rtl/jk_sequence_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | jk_sequence_monitor: lock/decode checker for the 8-state JK counter code.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module jk_sequence_monitor #(
  parameter int LAP_W = 8,
  parameter int ERR_W = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [3:0]       code,
  output logic             locked,
  output logic [2:0]       idx,
  output logic             hit,
  output logic             err,
  output logic             illegal,
  output logic [LAP_W-1:0] laps,
  output logic [ERR_W-1:0] errs
);

  typedef enum logic [0:0] {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       exp_q, exp_d;
  logic [2:0]       idx_q, idx_d;
  logic [LAP_W-1:0] laps_q, laps_d;
  logic [ERR_W-1:0] errs_q, errs_d;
  logic             hit_q, hit_d;
  logic             err_q, err_d;
  logic             illegal_q, illegal_d;

  logic             code_legal;
  logic [2:0]       code_idx;
  logic [3:0]       exp_code;

  // Reverse lookup: code -> sequence index, flagging the 8 unused codes.
  always_comb begin
    code_legal = 1'b1;
    code_idx   = 3'd0;
    case (code)
      4'b0000: code_idx = 3'd0;
      4'b1101: code_idx = 3'd1;
      4'b1011: code_idx = 3'd2;
      4'b1001: code_idx = 3'd3;
      4'b0110: code_idx = 3'd4;
      4'b1100: code_idx = 3'd5;
      4'b0011: code_idx = 3'd6;
      4'b1111: code_idx = 3'd7;
      default: code_legal = 1'b0;
    endcase
  end

  always_comb begin
    exp_code = 4'b0000;
    case (exp_q)
      3'd0: exp_code = 4'b0000;
      3'd1: exp_code = 4'b1101;
      3'd2: exp_code = 4'b1011;
      3'd3: exp_code = 4'b1001;
      3'd4: exp_code = 4'b0110;
      3'd5: exp_code = 4'b1100;
      3'd6: exp_code = 4'b0011;
      3'd7: exp_code = 4'b1111;
      default: exp_code = 4'b0000;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    exp_d     = exp_q;
    idx_d     = idx_q;
    laps_d    = laps_q;
    errs_d    = errs_q;
    hit_d     = 1'b0;
    err_d     = 1'b0;
    illegal_d = 1'b0;

    if (en) begin
      illegal_d = ~code_legal;
      case (state_q)
        HUNT: begin
          if (code == 4'b0000) begin
            state_d = LOCK;
            idx_d   = 3'd0;
            exp_d   = 3'd1;
          end else if (code_legal) begin
            idx_d = code_idx;
          end
        end
        LOCK: begin
          if (code == exp_code) begin
            hit_d = 1'b1;
            idx_d = exp_q;
            exp_d = exp_q + 3'd1;
            // exp==0 while locked only follows an accepted 1111: a full lap.
            if (exp_q == 3'd0) begin
              laps_d = laps_q + 1'b1;
            end
          end else begin
            err_d = 1'b1;
            if (errs_q != {ERR_W{1'b1}}) begin
              errs_d = errs_q + 1'b1;
            end
            if (code == 4'b0000) begin
              state_d = LOCK;
              idx_d   = 3'd0;
              exp_d   = 3'd1;
            end else begin
              state_d = HUNT;
              if (code_legal) begin
                idx_d = code_idx;
              end
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= HUNT;
      exp_q     <= 3'd1;
      idx_q     <= 3'd0;
      laps_q    <= '0;
      errs_q    <= '0;
      hit_q     <= 1'b0;
      err_q     <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      exp_q     <= exp_d;
      idx_q     <= idx_d;
      laps_q    <= laps_d;
      errs_q    <= errs_d;
      hit_q     <= hit_d;
      err_q     <= err_d;
      illegal_q <= illegal_d;
    end
  end

  assign locked  = (state_q == LOCK);
  assign idx     = idx_q;
  assign hit     = hit_q;
  assign err     = err_q;
  assign illegal = illegal_q;
  assign laps    = laps_q;
  assign errs    = errs_q;

endmodule
`default_nettype wire

// File: doc/jk_sequence_monitor.md
# jk_sequence_monitor

Receive-side checker for the 8-state JK synchronous counter sequence 0000→1101→1011→1001→0110→1100→0011→1111→0000. It samples a 4-bit code bus driven by that counter, or by any source claiming to emit the same sequence. It acquires lock on 0000, decodes each code to its sequence index, and flags out-of-order or illegal codes. It also keeps lap and error statistics. It sits downstream of the counter as a self-check and bring-up monitor.

## Interface
Parameters:
- LAP_W, 8, width of lap counter (wraps modulo 2^LAP_W)
- ERR_W, 4, width of error counter (saturates at 2^ERR_W−1)

Ports:
- clk  input  1  clock; all state changes on rising edge
- clr  input  1  reset, synchronous, active-high
- en  input  1  sample strobe; code is evaluated only when en=1
- code  input  4  observed counter state, bit 3 = MSB
- locked  output  1  monitor is tracking the sequence
- idx  output  3  sequence index of the last accepted legal code
- hit  output  1  one-cycle pulse: sampled code equalled expected code while locked
- err  output  1  one-cycle pulse: sequence violation while locked
- illegal  output  1  one-cycle pulse: sampled code is not one of the 8 sequence codes (any state)
- laps  output  LAP_W  completed laps
- errs  output  ERR_W  saturating count of err pulses

## Operation
- Decode table (idx:code): 0:0000, 1:1101, 2:1011, 3:1001, 4:0110, 5:1100, 6:0011, 7:1111. The other 8 codes are illegal.
- FSM has two states: HUNT and LOCK. Internal register exp[2:0] holds the expected next index.
- HUNT:
  - en=1 with code=0000: go to LOCK, idx←0, exp←1. No hit and no lap.
  - Any other code: stay in HUNT. idx updates if the code is legal and is held if it is illegal.
- LOCK, en=1:
  - code = table[exp]: hit=1, idx←exp, exp←exp+1 mod 8.
  - If that accepted code is 0000 (exp was 0, i.e. the wrap after 1111): laps←laps+1.
  - Mismatch, legal or illegal: err=1, errs←errs+1 saturating, go to HUNT. idx updates only if the code is legal.
  - Mismatch with code=0000: err=1 and re-acquire in the same cycle. Next state is LOCK with idx←0 and exp←1. No lap.
- illegal is asserted for any illegal code on an en=1 cycle, in either state. In LOCK it is accompanied by err.
- en=0: no state, idx, exp or counter change; hit, err and illegal are 0. Stalls of any length are transparent to sequence checking.
- laps wraps: 2^LAP_W−1 → 0.
- errs holds at all-ones once saturated. err still pulses.
- clr=1 overrides en.

## Timing
- All outputs are registered. Response to the en sample at edge N is visible after edge N; latency is 1 cycle.
- hit, err and illegal are high for exactly one cycle per qualifying sample. Back-to-back en samples give back-to-back pulses.
- hit and err are mutually exclusive.
- Reset values, applied on the first clk edge with clr=1:
  - locked=0, state HUNT, exp=1
  - idx=0, laps=0, errs=0
  - hit=0, err=0, illegal=0
- Reset mid-LOCK: the next cycle shows locked=0 and counters cleared. A sample presented with clr=1 is discarded.
- locked equals (state==LOCK) registered. It rises in the cycle after 0000 is accepted from HUNT. It falls in the cycle after a non-0000 mismatch.

## Test plan
- Reset then full sequence, en=1 every cycle, two laps: locked=1 after first 0000. hit pulses on 15 consecutive cycles. idx steps 0..7,0..7. laps=1 after the second 0000, 2 after the third.
- Stall: insert 3 cycles of en=0 between 1011 and 1001 -> no err. idx holds 2 during the stall, then reads 3.
- Skip: locked at idx=2, present 0110 -> err=1 for one cycle, errs=1, locked=0. Following 1100 -> no hit, stays HUNT.
- Illegal: locked at idx=4, present 0101 -> err=1, illegal=1, idx stays 4, HUNT. Then 0000 -> locked=1, idx=0, laps unchanged.
- Mismatch re-acquire: locked at idx=5, present 0000 -> err=1, locked stays 1, idx=0, laps unchanged. Next 1101 -> hit=1.
- Saturation/reset: with ERR_W=2, force 5 violations -> errs=3. Assert clr mid-LOCK -> next cycle locked=0, laps=0, errs=0, idx=0.
